vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- Scan/timing generator for the VGA display path. It produces the pixel-position stream that frame_detection and the other pixel-decode blocks consume, plus the hsync and vsync signals for the monitor.
- Standard 640x480@60 timing, driven from the system clock through an internal pixel-tick divider.
- Position convention matches the display path: x_pos is the line (row) index 0..479, y_pos is the column index 0..639.

Parameters:
- CLK_DIV, 4: system clocks per pixel tick; legal range 1..16.
- H_ACTIVE, 640: visible columns.
- H_FP, 16: horizontal front porch, in ticks.
- H_SYNC, 96: hsync width, in ticks.
- H_BP, 48: horizontal back porch, in ticks.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync active level; 0 means active-low.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high while in the active region.
- x_pos  out  9  line index 0..479; 0 when video_on=0.
- y_pos  out  10  column index 0..639; 0 when video_on=0.
- line_start  out  1  one-clk pulse when h_cnt enters 0.
- frame_start  out  1  one-clk pulse when (h_cnt,v_cnt) enters (0,0).

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Totals: H_TOTAL = sum of the four H parameters (800). V_TOTAL = sum of the four V parameters (525). Both counters are 10 bits; H_TOTAL and V_TOTAL must each be <= 1024.
- Divider: div counts 0..CLK_DIV-1 and wraps to 0. pix_tick = (div == CLK_DIV-1). With CLK_DIV=1, pix_tick is high every cycle.
- h_cnt: advances on pix_tick. At H_TOTAL-1 it wraps to 0 and v_cnt advances. v_cnt wraps at V_TOTAL-1 to 0.
- Reset values:
  - div=0, h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1.
  - hsync=vsync=~SYNC_POL (inactive).
  - video_on=0, x_pos=0, y_pos=0, line_start=0, frame_start=0.
- Consequence of the reset values: the first pix_tick after reset enters (0,0) and raises frame_start.
- All outputs are registered and updated on the clock edge at which pix_tick=1. Each output reflects the new counter value, i.e. zero added latency relative to the counters. Outputs hold between ticks.
- Decode rules:
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vsync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Width rules: x_pos = v_cnt[8:0] and y_pos = h_cnt when video_on, else 0.
- Pulses: line_start and frame_start are high for exactly one clk, in the cycle after the tick edge that entered h_cnt=0 (respectively (0,0)). They clear on the next clk regardless of CLK_DIV. At (0,0), frame_start and line_start assert together.
- Reset mid-frame: rst_n low forces the reset values immediately, without waiting for a clock. After release, timing restarts exactly as after power-up.
- No other inputs exist; the generator free-runs.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: adds output port frame_cnt, 8 bits.
  - Resets to 0.
  - Increments in the same clk edge that raises frame_start.
  - Wraps 255 -> 0.
  - The first frame after reset reads 1.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset release, CLK_DIV=4: frame_start is high in the cycle after the 4th rising edge post-release, with x_pos=0, y_pos=0, video_on=1, line_start=1.
- Line timing, CLK_DIV=4:
  - line_start period is 3200 clks.
  - hsync is low for 384 clks, starting at the tick where y_pos would be 656.
  - video_on falls at h_cnt=640; y_pos reads 0 there.
- Frame timing:
  - frame_start period is 1,680,000 clks.
  - vsync is low for exactly 2 lines (6400 clks), beginning at v_cnt=490.
  - x_pos peaks at 479 and never exceeds it.
- Reset mid-frame at v_cnt=200, h_cnt=300: rst_n low
  - -> hsync=vsync=1, video_on=0, positions 0, with no clk edge needed.
  - -> after release, the first frame_start occurs 4 edges later.
- CLK_DIV=1 build: line_start period 800 clks, frame_start period 420,000 clks, hsync low 96 clks.
- With VGA_FRAME_CNT_EN: frame_cnt=1 after the first frame_start; it reaches 255, then wraps to 0 on the 256th frame_start.

Source files
------------

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: free-running 640x480@60 scan/timing generator.
// A clock divider produces a pixel tick; horizontal and vertical counters
// advance on that tick and every output is registered from the counters'
// next values, so outputs line up with the counters with no extra latency.
// x_pos is the line (row) index and y_pos is the column index.
// Optional build macro VGA_FRAME_CNT_EN adds an 8-bit frame counter output.
// H_TOTAL and V_TOTAL must each be <= 1024 and CLK_DIV must be 1..16.
module vga_scan_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [8:0] x_pos,
    output logic [9:0] y_pos,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    // Sync windows kept as int so an end bound of 1024 cannot wrap.
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;

    logic [3:0] div;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       pix_tick;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       vis_nxt;
    logic       hs_act_nxt;
    logic       vs_act_nxt;
    logic       at_origin_nxt;

    assign pix_tick = (div == DIV_LAST);

    // Next counter position and the decode of that position.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
        vis_nxt       = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        hs_act_nxt    = (int'(h_nxt) >= HS_BEG) && (int'(h_nxt) < HS_END);
        vs_act_nxt    = (int'(v_nxt) >= VS_BEG) && (int'(v_nxt) < VS_END);
        at_origin_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end

    // Pixel-tick divider and scan counters; reset parks the counters on the
    // last position so the first tick lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            h_cnt <= H_LAST;
            v_cnt <= V_LAST;
        end else if (pix_tick) begin
            div   <= '0;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end else begin
            div   <= div + 4'd1;
        end
    end

    // Level outputs follow the new counter value on each tick and hold between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b0;
            x_pos    <= '0;
            y_pos    <= '0;
        end else if (pix_tick) begin
            hsync    <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
            vsync    <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
            video_on <= vis_nxt;
            x_pos    <= vis_nxt ? v_nxt[8:0] : 9'd0;
            y_pos    <= vis_nxt ? h_nxt : 10'd0;
        end
    end

    // Single-clock pulses: re-evaluated every clock so they drop after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_tick && (h_nxt == 10'd0);
            frame_start <= pix_tick && at_origin_nxt;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Frame counter steps on the same edge that raises frame_start, wrapping at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (pix_tick && at_origin_nxt) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen.
// Instance 0: default timing, CLK_DIV=4.  Instance 1: reduced timing, CLK_DIV=4.
// Instance 2: default timing, CLK_DIV=1.  Instance 3: reduced timing, CLK_DIV=1.
// Reduced timings keep whole frames short enough to observe several of them.
module tb_vga_scan_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int edges = 0;   // rising edges since the last reset release
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // ---------------- DUT outputs ----------------
    logic       hs [4];
    logic       vs [4];
    logic       vo [4];
    logic [8:0] xp [4];
    logic [9:0] yp [4];
    logic       ls [4];
    logic       fs [4];
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc [4];
`endif

    vga_scan_gen #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
        .x_pos(xp[0]), .y_pos(yp[0]), .line_start(ls[0]), .frame_start(fs[0])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc[0])
`endif
    );

    vga_scan_gen #(.CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
        .x_pos(xp[1]), .y_pos(yp[1]), .line_start(ls[1]), .frame_start(fs[1])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc[1])
`endif
    );

    vga_scan_gen #(.CLK_DIV(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]),
        .x_pos(xp[2]), .y_pos(yp[2]), .line_start(ls[2]), .frame_start(fs[2])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc[2])
`endif
    );

    vga_scan_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .hsync(hs[3]), .vsync(vs[3]), .video_on(vo[3]),
        .x_pos(xp[3]), .y_pos(yp[3]), .line_start(ls[3]), .frame_start(fs[3])
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc[3])
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // which: 0 line_start, 1 frame_start, 2 hsync, 3 vsync, other video_on
    function automatic logic sig(input int i, input int which);
        case (which)
            0:       return ls[i];
            1:       return fs[i];
            2:       return hs[i];
            3:       return vs[i];
            default: return vo[i];
        endcase
    endfunction

    task automatic wait_lvl(input int i, input int which, input logic lvl,
                            input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (sig(i, which) == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Clocks between two successive rising edges of a signal; -1 on timeout.
    task automatic period(input int i, input int which, input int budget, output int d);
        bit ok0, ok1, ok2, ok3;
        int t0;
        wait_lvl(i, which, 1'b0, budget, ok0);
        wait_lvl(i, which, 1'b1, budget, ok1);
        t0 = cyc;
        wait_lvl(i, which, 1'b0, budget, ok2);
        wait_lvl(i, which, 1'b1, budget, ok3);
        d = (ok0 && ok1 && ok2 && ok3) ? cyc - t0 : -1;
    endtask

    // Clocks a signal stays at lvl once it enters it; -1 on timeout.
    task automatic width(input int i, input int which, input logic lvl,
                         input int budget, output int d);
        bit ok0, ok1, ok2;
        int t0;
        wait_lvl(i, which, ~lvl, budget, ok0);
        wait_lvl(i, which, lvl, budget, ok1);
        t0 = cyc;
        wait_lvl(i, which, ~lvl, budget, ok2);
        d = (ok0 && ok1 && ok2) ? cyc - t0 : -1;
    endtask

    task automatic wait_edges(input int k);
        for (int n = 0; n < 5000 && edges < k; n++) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    // k = rising edges after reset release; sampled on the following falling edge.
    typedef struct {
        int inst;
        int k;
        int vo, hs, vs, x, y, ls, fs;
    } vec_t;

    localparam int NV = 30;
    vec_t vt [NV];

    initial begin
        int d;
        int xmax;
        bit ok;

        //        inst  k     vo hs vs  x    y   ls fs
        vt[0]  = '{1,    0,    0, 1, 1, 0,   0,  0, 0};
        vt[1]  = '{0,    0,    0, 1, 1, 0,   0,  0, 0};
        vt[2]  = '{0,    3,    0, 1, 1, 0,   0,  0, 0};
        vt[3]  = '{1,    4,    1, 1, 1, 0,   0,  1, 1};
        vt[4]  = '{0,    4,    1, 1, 1, 0,   0,  1, 1};
        vt[5]  = '{0,    5,    1, 1, 1, 0,   0,  0, 0};
        vt[6]  = '{1,    5,    1, 1, 1, 0,   0,  0, 0};
        vt[7]  = '{0,    8,    1, 1, 1, 0,   1,  0, 0};
        vt[8]  = '{1,   44,    0, 0, 1, 0,   0,  0, 0};
        vt[9]  = '{1,   48,    0, 0, 1, 0,   0,  0, 0};
        vt[10] = '{1,   52,    0, 0, 1, 0,   0,  0, 0};
        vt[11] = '{1,   56,    0, 1, 1, 0,   0,  0, 0};
        vt[12] = '{1,   68,    1, 1, 1, 1,   0,  1, 0};
        vt[13] = '{1,   69,    1, 1, 1, 1,   0,  0, 0};
        vt[14] = '{1,  352,    1, 1, 1, 5,   7,  0, 0};
        vt[15] = '{1,  356,    0, 1, 1, 0,   0,  0, 0};
        vt[16] = '{1,  448,    0, 1, 1, 0,   0,  0, 0};
        vt[17] = '{1,  452,    0, 1, 0, 0,   0,  1, 0};
        vt[18] = '{1,  576,    0, 1, 0, 0,   0,  0, 0};
        vt[19] = '{1,  580,    0, 1, 1, 0,   0,  1, 0};
        vt[20] = '{1,  708,    1, 1, 1, 0,   0,  1, 1};
        vt[21] = '{1,  709,    1, 1, 1, 0,   0,  0, 0};
        vt[22] = '{0, 2560,    1, 1, 1, 0, 639,  0, 0};
        vt[23] = '{0, 2564,    0, 1, 1, 0,   0,  0, 0};
        vt[24] = '{0, 2624,    0, 1, 1, 0,   0,  0, 0};
        vt[25] = '{0, 2628,    0, 0, 1, 0,   0,  0, 0};
        vt[26] = '{0, 3008,    0, 0, 1, 0,   0,  0, 0};
        vt[27] = '{0, 3012,    0, 1, 1, 0,   0,  0, 0};
        vt[28] = '{0, 3204,    1, 1, 1, 1,   0,  1, 0};
        vt[29] = '{0, 3205,    1, 1, 1, 1,   0,  0, 0};

        // Power-up reset, released on a falling edge.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int v = 0; v < NV; v++) begin
            wait_edges(vt[v].k);
            check($sformatf("v%0d.edges", v), edges, vt[v].k);
            check($sformatf("v%0d.video_on", v), int'(vo[vt[v].inst]), vt[v].vo);
            check($sformatf("v%0d.hsync", v), int'(hs[vt[v].inst]), vt[v].hs);
            check($sformatf("v%0d.vsync", v), int'(vs[vt[v].inst]), vt[v].vs);
            check($sformatf("v%0d.x_pos", v), int'(xp[vt[v].inst]), vt[v].x);
            check($sformatf("v%0d.y_pos", v), int'(yp[vt[v].inst]), vt[v].y);
            check($sformatf("v%0d.line_start", v), int'(ls[vt[v].inst]), vt[v].ls);
            check($sformatf("v%0d.frame_start", v), int'(fs[vt[v].inst]), vt[v].fs);
        end

        // Line/frame geometry measurements.
        width(0, 2, 1'b0, 4000, d);   check("a.hsync_low", d, 384);
        period(0, 0, 4000, d);        check("a.line_period", d, 3200);
        period(1, 1, 1000, d);        check("b.frame_period", d, 704);
        width(1, 3, 1'b0, 1000, d);   check("b.vsync_low", d, 128);
        period(1, 0, 200, d);         check("b.line_period", d, 64);
        width(1, 2, 1'b0, 200, d);    check("b.hsync_low", d, 12);
        xmax = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            if (int'(xp[1]) > xmax) xmax = int'(xp[1]);
        end
        check("b.x_pos_peak", xmax, 5);
        period(2, 0, 2000, d);        check("c.line_period", d, 800);
        width(2, 2, 1'b0, 2000, d);   check("c.hsync_low", d, 96);
        period(3, 0, 100, d);         check("d.line_period", d, 8);
        period(3, 1, 200, d);         check("d.frame_period", d, 48);
        width(3, 2, 1'b0, 100, d);    check("d.hsync_low", d, 2);

        // Mid-frame reset on instance b at row 3, column 5.
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (xp[1] == 9'd3 && yp[1] == 10'd5) begin
                ok = 1'b1;
                break;
            end
        end
        check("b.found_3_5", int'(ok), 1);
        #2 rst_n = 1'b0;
        #1;
        check("b.rst_async.hsync", int'(hs[1]), 1);
        check("b.rst_async.vsync", int'(vs[1]), 1);
        check("b.rst_async.video_on", int'(vo[1]), 0);
        check("b.rst_async.x_pos", int'(xp[1]), 0);
        check("b.rst_async.y_pos", int'(yp[1]), 0);
        check("b.rst_async.frame_start", int'(fs[1]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
`ifdef VGA_FRAME_CNT_EN
        check("d.frame_cnt_reset", int'(fc[3]), 0);
        wait_edges(1);
        check("d.frame_start_k1", int'(fs[3]), 1);
        check("d.frame_cnt_first", int'(fc[3]), 1);
`endif
        wait_edges(3);
        check("b.rerst.fs_k3", int'(fs[1]), 0);
        check("b.rerst.vo_k3", int'(vo[1]), 0);
        wait_edges(4);
        check("b.rerst.fs_k4", int'(fs[1]), 1);
        check("b.rerst.ls_k4", int'(ls[1]), 1);
        check("b.rerst.vo_k4", int'(vo[1]), 1);
        check("b.rerst.x_k4", int'(xp[1]), 0);
        check("b.rerst.y_k4", int'(yp[1]), 0);

`ifdef VGA_FRAME_CNT_EN
        // Instance d already showed frame 1; count the remaining frame starts.
        for (int f = 2; f <= 256; f++) begin
            bit ok0, ok1;
            wait_lvl(3, 1, 1'b0, 100, ok0);
            wait_lvl(3, 1, 1'b1, 100, ok1);
            if (!(ok0 && ok1)) begin
                check("d.frame_start_timeout", f, 0);
                break;
            end
            if (f == 2)   check("d.frame_cnt_2", int'(fc[3]), 2);
            if (f == 255) check("d.frame_cnt_255", int'(fc[3]), 255);
            if (f == 256) check("d.frame_cnt_wrap", int'(fc[3]), 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
